// File: rtl/thermal_pkg.sv
// Shared types and constants for the thermal monitor: FSM encoding, sizing and
// the saturating alarm-counter arithmetic.
package thermal_pkg;

    typedef enum logic [1:0] {
        ST_NORMAL   = 2'd0,
        ST_THROTTLE = 2'd1,
        ST_SHUTDOWN = 2'd2
    } therm_state_e;

    localparam int NUM_SENSORS = 3;
    localparam int TEMP_W      = 8;
    localparam int AVG_LOG2    = 2;
    localparam int WIN_DEPTH   = 1 << AVG_LOG2;
    localparam int SUM_W       = TEMP_W + AVG_LOG2;
    localparam int FILL_W      = AVG_LOG2 + 1;
    localparam int CNT_W       = 16;
    localparam int IDX_W       = 2;

    // Adds up to three simultaneous entries; clamps at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                 input logic [1:0] inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, cnt} + {{(CNT_W-1){1'b0}}, inc};
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    function automatic logic [1:0] count_entries(input logic [NUM_SENSORS-1:0] entry);
        logic [1:0] c;
        c = '0;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            c = c + {1'b0, entry[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/thermal_monitor_if.sv
// Temperature-sensor bus between the sensor block (master) and the monitor (slave).
// sample_tick is a one-cycle valid strobe with no ready: the monitor accepts every tick.
interface thermal_monitor_if import thermal_pkg::*;;

    logic              sample_tick;
    logic [TEMP_W-1:0] temp1;
    logic [TEMP_W-1:0] temp2;
    logic [TEMP_W-1:0] temp3;

    modport master (
        output sample_tick,
        output temp1,
        output temp2,
        output temp3
    );

    modport slave (
        input sample_tick,
        input temp1,
        input temp2,
        input temp3
    );

endinterface

// File: rtl/thermal_channel.sv
// One sensor channel: 4-deep moving average plus a NORMAL/THROTTLE/SHUTDOWN FSM
// with hysteresis; flags the cycle on which it enters SHUTDOWN.
module thermal_channel import thermal_pkg::*; #(
    parameter int unsigned WARN_T = 70,
    parameter int unsigned CRIT_T = 85,
    parameter int unsigned HYST   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_tick,
    input  logic [TEMP_W-1:0] temp,
    input  logic              avg_valid,
    input  logic              shutdown_clr,
    output logic [TEMP_W-1:0] avg_next,
    output logic              throttle,
    output logic              shutdown,
    output logic              entry,
    output therm_state_e      state
);

    localparam logic [TEMP_W-1:0] WARN_L      = TEMP_W'(WARN_T);
    localparam logic [TEMP_W-1:0] CRIT_L      = TEMP_W'(CRIT_T);
    localparam logic [TEMP_W-1:0] WARN_EXIT_L = TEMP_W'(WARN_T - HYST);
    localparam logic [TEMP_W-1:0] CRIT_EXIT_L = TEMP_W'(CRIT_T - HYST);

    logic [TEMP_W-1:0] hist [WIN_DEPTH];
    logic [SUM_W-1:0]  sum;
    logic [SUM_W-1:0]  sum_next;
    logic [TEMP_W-1:0] avg;
    logic              upd;
    logic              eval;
    therm_state_e      nxt;

    // The oldest sample is always part of sum, so the subtraction cannot underflow.
    always_comb begin
        sum_next = sum + SUM_W'(temp) - SUM_W'(hist[WIN_DEPTH-1]);
    end

    assign avg_next = sum_next[SUM_W-1:AVG_LOG2];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WIN_DEPTH; i++) begin
                hist[i] <= '0;
            end
            sum <= '0;
            avg <= '0;
            upd <= 1'b0;
        end else begin
            upd <= sample_tick;
            if (sample_tick) begin
                hist[0] <= temp;
                for (int i = 1; i < WIN_DEPTH; i++) begin
                    hist[i] <= hist[i-1];
                end
                sum <= sum_next;
                avg <= avg_next;
            end
        end
    end

    // The FSM looks at the average one cycle after it was refreshed.
    assign eval = upd & avg_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_NORMAL;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        if (eval) begin
            if (avg >= CRIT_L) begin
                nxt = ST_SHUTDOWN;
            end else begin
                case (state)
                    ST_NORMAL: begin
                        if (avg >= WARN_L) nxt = ST_THROTTLE;
                    end
                    ST_THROTTLE: begin
                        if (avg < WARN_EXIT_L) nxt = ST_NORMAL;
                    end
                    ST_SHUTDOWN: begin
                        if (shutdown_clr && (avg < CRIT_EXIT_L)) nxt = ST_THROTTLE;
                    end
                    default: nxt = ST_NORMAL;
                endcase
            end
        end
    end

    always_comb begin
        throttle = (state != ST_NORMAL);
        shutdown = (state == ST_SHUTDOWN);
        entry    = (nxt == ST_SHUTDOWN) && (state != ST_SHUTDOWN);
    end

endmodule

// File: rtl/thermal_monitor.sv
// Thermal monitor top: three filtered sensor channels, window fill tracking,
// hottest-sensor selection and a saturating SHUTDOWN-entry counter.
module thermal_monitor import thermal_pkg::*; #(
    parameter int unsigned WARN_T = 70,
    parameter int unsigned CRIT_T = 85,
    parameter int unsigned HYST   = 5
) (
    input  logic                              clk,
    input  logic                              rst,
    thermal_monitor_if.slave                  bus,
    input  logic                              shutdown_clr,
    output logic                              avg_valid,
    output logic [NUM_SENSORS-1:0]            throttle,
    output logic [NUM_SENSORS-1:0]            shutdown,
    output logic [TEMP_W-1:0]                 max_temp,
    output logic [IDX_W-1:0]                  max_idx,
    output logic [CNT_W-1:0]                  alarm_count,
    output therm_state_e [NUM_SENSORS-1:0]    fsm_state
);

    logic [TEMP_W-1:0]      temp_arr [NUM_SENSORS];
    logic [TEMP_W-1:0]      avg_nx   [NUM_SENSORS];
    logic [NUM_SENSORS-1:0] entry;
    logic [FILL_W-1:0]      fill;
    logic [TEMP_W-1:0]      cand_temp;
    logic [IDX_W-1:0]       cand_idx;

    assign temp_arr[0] = bus.temp1;
    assign temp_arr[1] = bus.temp2;
    assign temp_arr[2] = bus.temp3;

    for (genvar g = 0; g < NUM_SENSORS; g++) begin : g_ch
        thermal_channel #(
            .WARN_T (WARN_T),
            .CRIT_T (CRIT_T),
            .HYST   (HYST)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .sample_tick  (bus.sample_tick),
            .temp         (temp_arr[g]),
            .avg_valid    (avg_valid),
            .shutdown_clr (shutdown_clr),
            .avg_next     (avg_nx[g]),
            .throttle     (throttle[g]),
            .shutdown     (shutdown[g]),
            .entry        (entry[g]),
            .state        (fsm_state[g])
        );
    end

    // Fill counter stops at the window depth; only a reset starts a refill.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill <= '0;
        end else if (bus.sample_tick && (fill != FILL_W'(WIN_DEPTH))) begin
            fill <= fill + 1'b1;
        end
    end

    assign avg_valid = (fill == FILL_W'(WIN_DEPTH));

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        cand_temp = avg_nx[0];
        cand_idx  = '0;
        for (int i = 1; i < NUM_SENSORS; i++) begin
            if (avg_nx[i] > cand_temp) begin
                cand_temp = avg_nx[i];
                cand_idx  = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            max_temp <= '0;
            max_idx  <= '0;
        end else if (bus.sample_tick) begin
            max_temp <= cand_temp;
            max_idx  <= cand_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alarm_count <= '0;
        end else begin
            alarm_count <= sat_add(alarm_count, count_entries(entry));
        end
    end

endmodule

// File: tb/tb_thermal_monitor.sv
// Directed bench for thermal_monitor: filtering, hysteresis, sticky shutdown,
// simultaneous alarms with saturation, mid-run reset and hottest-sensor tracking.
module tb_thermal_monitor;
    import thermal_pkg::*;

    logic                           clk = 1'b0;
    logic                           rst = 1'b1;
    logic                           shutdown_clr = 1'b0;
    logic                           avg_valid;
    logic [2:0]                     throttle;
    logic [2:0]                     shutdown;
    logic [7:0]                     max_temp;
    logic [1:0]                     max_idx;
    logic [15:0]                    alarm_count;
    therm_state_e [NUM_SENSORS-1:0] fsm_state;

    int total = 0;
    int bad   = 0;

    thermal_monitor_if bus();

    thermal_monitor dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .shutdown_clr (shutdown_clr),
        .avg_valid    (avg_valid),
        .throttle     (throttle),
        .shutdown     (shutdown),
        .max_temp     (max_temp),
        .max_idx      (max_idx),
        .alarm_count  (alarm_count),
        .fsm_state    (fsm_state)
    );

    always #5 clk = ~clk;

    // Called at a negedge; returns at the next negedge with the tick's registered results visible.
    task automatic tick(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        bus.temp1 = a;
        bus.temp2 = b;
        bus.temp3 = c;
        bus.sample_tick = 1'b1;
        @(negedge clk);
        bus.sample_tick = 1'b0;
    endtask

    task automatic eval_step(input logic clr);
        shutdown_clr = clr;
        @(negedge clk);
        shutdown_clr = 1'b0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        total++; if (avg_valid !== 1'b0) begin bad++; $display("FAIL rst_avg_valid got=%b want=0", avg_valid); end
        total++; if (throttle !== 3'b000) begin bad++; $display("FAIL rst_throttle got=%b want=000", throttle); end
        total++; if (shutdown !== 3'b000) begin bad++; $display("FAIL rst_shutdown got=%b want=000", shutdown); end
        total++; if (max_temp !== 8'd0 || max_idx !== 2'd0) begin bad++; $display("FAIL rst_max got=%0d/%0d want=0/0", max_temp, max_idx); end
        total++; if (alarm_count !== 16'h0000) begin bad++; $display("FAIL rst_alarm got=%h want=0000", alarm_count); end
        total++; if (fsm_state !== 6'b000000) begin bad++; $display("FAIL rst_fsm got=%b want=000000", fsm_state); end
    endtask

    task automatic test_fill;
        do_reset();
        repeat (3) tick(8'd80, 8'd80, 8'd80);
        total++; if (avg_valid !== 1'b0) begin bad++; $display("FAIL fill3_avg_valid got=%b want=0", avg_valid); end
        eval_step(1'b0);
        total++; if (throttle !== 3'b000) begin bad++; $display("FAIL fill3_throttle got=%b want=000", throttle); end
        tick(8'd80, 8'd80, 8'd80);
        total++; if (avg_valid !== 1'b1) begin bad++; $display("FAIL fill4_avg_valid got=%b want=1", avg_valid); end
        total++; if (throttle !== 3'b000) begin bad++; $display("FAIL fill4_throttle_early got=%b want=000", throttle); end
        eval_step(1'b0);
        total++; if (throttle !== 3'b111) begin bad++; $display("FAIL fill4_throttle got=%b want=111", throttle); end
        total++; if (max_temp !== 8'd80 || max_idx !== 2'd0) begin bad++; $display("FAIL fill4_max got=%0d/%0d want=80/0", max_temp, max_idx); end
        total++; if (fsm_state !== 6'b010101) begin bad++; $display("FAIL fill4_fsm got=%b want=010101", fsm_state); end
    endtask

    task automatic test_hysteresis;
        do_reset();
        repeat (4) tick(8'd70, 8'd0, 8'd0);
        eval_step(1'b0);
        total++; if (throttle !== 3'b001) begin bad++; $display("FAIL hyst_enter70 got=%b want=001", throttle); end
        repeat (4) tick(8'd66, 8'd0, 8'd0);
        eval_step(1'b0);
        total++; if (throttle !== 3'b001) begin bad++; $display("FAIL hyst_hold66 got=%b want=001", throttle); end
        tick(8'd64, 8'd0, 8'd0);
        eval_step(1'b0);
        total++; if (throttle !== 3'b001) begin bad++; $display("FAIL hyst_hold65a got=%b want=001", throttle); end
        tick(8'd64, 8'd0, 8'd0);
        eval_step(1'b0);
        total++; if (throttle !== 3'b001) begin bad++; $display("FAIL hyst_hold65b got=%b want=001", throttle); end
        tick(8'd64, 8'd0, 8'd0);
        eval_step(1'b0);
        total++; if (throttle !== 3'b000) begin bad++; $display("FAIL hyst_exit64 got=%b want=000", throttle); end
    endtask

    task automatic test_shutdown;
        do_reset();
        repeat (4) tick(8'd0, 8'd90, 8'd0);
        eval_step(1'b0);
        total++; if (shutdown !== 3'b010) begin bad++; $display("FAIL sd_enter got=%b want=010", shutdown); end
        total++; if (throttle !== 3'b010) begin bad++; $display("FAIL sd_enter_throttle got=%b want=010", throttle); end
        total++; if (alarm_count !== 16'd1) begin bad++; $display("FAIL sd_alarm got=%h want=0001", alarm_count); end
        tick(8'd0, 8'd90, 8'd0);
        eval_step(1'b1);
        total++; if (shutdown !== 3'b010) begin bad++; $display("FAIL sd_clr_hot got=%b want=010", shutdown); end
        repeat (3) tick(8'd0, 8'd78, 8'd0);
        eval_step(1'b0);
        eval_step(1'b1);
        tick(8'd0, 8'd78, 8'd0);
        eval_step(1'b0);
        total++; if (shutdown !== 3'b010) begin bad++; $display("FAIL sd_clr_not_queued got=%b want=010", shutdown); end
        tick(8'd0, 8'd78, 8'd0);
        eval_step(1'b1);
        total++; if (shutdown !== 3'b000) begin bad++; $display("FAIL sd_release got=%b want=000", shutdown); end
        total++; if (throttle !== 3'b010) begin bad++; $display("FAIL sd_release_throttle got=%b want=010", throttle); end
        total++; if (alarm_count !== 16'd1) begin bad++; $display("FAIL sd_release_alarm got=%h want=0001", alarm_count); end
    endtask

    task automatic test_simultaneous;
        do_reset();
        repeat (4) tick(8'd85, 8'd85, 8'd85);
        eval_step(1'b0);
        total++; if (alarm_count !== 16'd3) begin bad++; $display("FAIL sim_alarm got=%h want=0003", alarm_count); end
        total++; if (shutdown !== 3'b111) begin bad++; $display("FAIL sim_shutdown got=%b want=111", shutdown); end
        total++; if (max_temp !== 8'd85 || max_idx !== 2'd0) begin bad++; $display("FAIL sim_max got=%0d/%0d want=85/0", max_temp, max_idx); end
    endtask

    task automatic test_ramp;
        logic [7:0] r1 [7];
        logic [7:0] r2 [7];
        logic [7:0] r3 [7];
        logic [7:0] emax [7];
        logic [1:0] eidx [7];
        r1   = '{8'd89, 8'd90, 8'd30, 8'd31, 8'd32, 8'd33, 8'd34};
        r2   = '{8'd10, 8'd20, 8'd40, 8'd50, 8'd250, 8'd250, 8'd0};
        r3   = '{8'd50, 8'd50, 8'd50, 8'd50, 8'd50, 8'd255, 8'd255};
        emax = '{8'd22, 8'd44, 8'd52, 8'd60, 8'd90, 8'd147, 8'd152};
        eidx = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            tick(r1[i], r2[i], r3[i]);
            total++;
            if (max_temp !== emax[i] || max_idx !== eidx[i]) begin
                bad++;
                $display("FAIL ramp_max[%0d] got=%0d/%0d want=%0d/%0d", i, max_temp, max_idx, emax[i], eidx[i]);
            end
        end
    endtask

    // Pattern 200,0,200,0,0 with clr held high gives two SHUTDOWN entries per sensor every five ticks.
    task automatic test_saturation;
        logic [7:0] v;
        do_reset();
        shutdown_clr = 1'b1;
        for (int n = 1; n <= 54611; n++) begin
            v = (((n - 1) % 5 == 0) || ((n - 1) % 5 == 2)) ? 8'd200 : 8'd0;
            tick(v, v, v);
        end
        @(negedge clk);
        total++; if (alarm_count !== 16'hFFFC) begin bad++; $display("FAIL sat_bulk got=%h want=FFFC", alarm_count); end
        tick(8'd0, 8'd0, 8'd0);
        tick(8'd200, 8'd200, 8'd0);
        @(negedge clk);
        total++; if (alarm_count !== 16'hFFFE) begin bad++; $display("FAIL sat_fffe got=%h want=FFFE", alarm_count); end
        total++; if (shutdown !== 3'b011) begin bad++; $display("FAIL sat_pair_shutdown got=%b want=011", shutdown); end
        repeat (4) tick(8'd0, 8'd0, 8'd0);
        @(negedge clk);
        shutdown_clr = 1'b0;
        total++; if (throttle !== 3'b000) begin bad++; $display("FAIL sat_cooled got=%b want=000", throttle); end
        repeat (4) tick(8'd85, 8'd85, 8'd85);
        eval_step(1'b0);
        total++; if (alarm_count !== 16'hFFFF) begin bad++; $display("FAIL sat_clamp got=%h want=FFFF", alarm_count); end
        total++; if (shutdown !== 3'b111) begin bad++; $display("FAIL sat_shutdown got=%b want=111", shutdown); end
    endtask

    task automatic test_reset_mid;
        do_reset();
        total++; if (shutdown !== 3'b000 || throttle !== 3'b000) begin bad++; $display("FAIL mid_rst_fsm got=%b/%b want=000/000", shutdown, throttle); end
        total++; if (alarm_count !== 16'h0000) begin bad++; $display("FAIL mid_rst_alarm got=%h want=0000", alarm_count); end
        total++; if (avg_valid !== 1'b0 || max_temp !== 8'd0) begin bad++; $display("FAIL mid_rst_avg got=%b/%0d want=0/0", avg_valid, max_temp); end
        repeat (3) tick(8'd90, 8'd90, 8'd90);
        eval_step(1'b0);
        total++; if (avg_valid !== 1'b0 || shutdown !== 3'b000) begin bad++; $display("FAIL mid_refill3 got=%b/%b want=0/000", avg_valid, shutdown); end
        tick(8'd90, 8'd90, 8'd90);
        total++; if (avg_valid !== 1'b1) begin bad++; $display("FAIL mid_refill4_valid got=%b want=1", avg_valid); end
        eval_step(1'b0);
        total++; if (shutdown !== 3'b111 || alarm_count !== 16'd3) begin bad++; $display("FAIL mid_refill4_sd got=%b/%h want=111/0003", shutdown, alarm_count); end
    endtask

    initial begin
        bus.sample_tick = 1'b0;
        bus.temp1 = '0;
        bus.temp2 = '0;
        bus.temp3 = '0;
        @(negedge clk);
        test_reset();
        test_fill();
        test_hysteresis();
        test_shutdown();
        test_simultaneous();
        test_ramp();
        test_saturation();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
